// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: decode constants,
// the M-extension funct3 encodings and the sequencer state type.
package muldiv_ctrl_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] M_FUNCT7      = 7'b0000001;
  localparam int         MD_DIV_CYCLES = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } m_funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] trial;

  assign trial = {rem_i, bit_i};
  assign q_o   = (trial >= {1'b0, divisor_i});
  // The remainder always stays below the divisor, so W bits hold either outcome.
  assign rem_o = q_o ? W'(trial - {1'b0, divisor_i}) : trial[W-1:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: registered multiplier path plus a 32-step restoring divider.
// Optional MULDIV_DIV_FAST_EN returns divide-by-zero/overflow results at accept.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam logic [4:0] LAST_CNT = 5'(DIV_CYCLES - 1);

  muldiv_state_e   state_q, state_d;
  m_funct3_e       funct3_q, funct3_d;
  logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [XLEN-1:0] rem_q, rem_d, result_q, result_d;
  logic [4:0]      rd_q, rd_d, rd_out_q, rd_out_d, cnt_q, cnt_d;
  logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d;

  logic            mul_sa, mul_sb;
  logic [63:0]     mul_a64, mul_b64, mul_prod;

  assign mul_sa   = (funct3_q == F3_MULH) || (funct3_q == F3_MULHSU);
  assign mul_sb   = (funct3_q == F3_MULH);
  assign mul_a64  = {{32{mul_sa & op_a_q[XLEN-1]}}, op_a_q};
  assign mul_b64  = {{32{mul_sb & op_b_q[XLEN-1]}}, op_b_q};
  assign mul_prod = mul_a64 * mul_b64;

  // During DIV, op_a_q shifts dividend bits out of the top and quotient bits in at the bottom.
  logic [XLEN-1:0] step_rem, quo_fin;
  logic            step_q;

  div_step #(.W(XLEN)) u_div_step (
    .rem_i     (rem_q),
    .bit_i     (op_a_q[XLEN-1]),
    .divisor_i (op_b_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign quo_fin = {op_a_q[XLEN-2:0], step_q};

  logic a_neg, b_neg, b_zero;
  assign a_neg  = ~funct3_i[0] & op_a_i[XLEN-1];
  assign b_neg  = ~funct3_i[0] & op_b_i[XLEN-1];
  assign b_zero = (op_b_i == '0);

`ifdef MULDIV_DIV_FAST_EN
  logic div_ovf;
  assign div_ovf = a_neg && b_neg && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
`endif

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    rem_d    = rem_q;
    result_d = result_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    cnt_d    = cnt_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;

    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            funct3_d = m_funct3_e'(funct3_i);
            rd_d     = rd_i;
            if (!funct3_i[2]) begin
              op_a_d  = op_a_i;
              op_b_d  = op_b_i;
              state_d = MUL;
            end else begin
              op_a_d  = a_neg ? -op_a_i : op_a_i;
              op_b_d  = b_neg ? -op_b_i : op_b_i;
              // A zero divisor yields all-ones whatever the dividend sign.
              neg_q_d = (a_neg ^ b_neg) & ~b_zero;
              neg_r_d = a_neg;
              rem_d   = '0;
              cnt_d   = '0;
              state_d = DIV;
`ifdef MULDIV_DIV_FAST_EN
              if (b_zero || div_ovf) begin
                if (funct3_i[1]) result_d = b_zero ? op_a_i : '0;
                else             result_d = b_zero ? '1 : op_a_i;
                rd_out_d = rd_i;
                state_d  = DONE;
              end
`endif
            end
          end
        end
        MUL: begin
          result_d = (funct3_q == F3_MUL) ? mul_prod[31:0] : mul_prod[63:32];
          rd_out_d = rd_q;
          state_d  = DONE;
        end
        DIV: begin
          rem_d  = step_rem;
          op_a_d = quo_fin;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == LAST_CNT) begin
            if ((funct3_q == F3_REM) || (funct3_q == F3_REMU))
              result_d = neg_r_q ? -step_rem : step_rem;
            else
              result_d = neg_q_q ? -quo_fin : quo_fin;
            rd_out_d = rd_q;
            state_d  = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      funct3_q <= F3_MUL;
      op_a_q   <= '0;
      op_b_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      cnt_q    <= cnt_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;
  assign rd_o     = rd_out_q;

endmodule
